// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//
// Bit-serial add/subtract unit. This is the sequential, area-reduced
// counterpart of a parallel ripple adder. Both operands are taken in over a
// valid/ready handshake. The unit then walks a single full-adder cell across
// the operands, one bit per clock and LSB first. The result is returned over a
// second valid/ready handshake.
//
// Subtraction is A + ~B + ~borrow_in. This uses the same adder cell as the add
// path. The carry-out of that sum is the inverse of the borrow-out.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      a/b/sub/cin are valid
//   in_ready   out  1      unit can accept operands (IDLE only)
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   sub        in   1      0: add, 1: subtract
//   cin        in   1      add: carry-in, subtract: borrow-in
//   out_valid  out  1      result/cout/ovf are valid
//   out_ready  in   1      consumer accepts the result
//   result     out  WIDTH  sum/difference, mod 2^WIDTH
//   cout       out  1      add: carry-out, subtract: borrow-out
//   ovf        out  1      signed (two's complement) overflow
//   busy       out  1      high while shifting or holding a result
// -----------------------------------------------------------------------------
module serial_addsub #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             busy
);

   // The counter must hold the values 0..WIDTH-1. One spare bit keeps the
   // width sane for WIDTH values that are exact powers of two.
   localparam int CW = $clog2(WIDTH) + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]       state_q,  state_d;
   logic [WIDTH-1:0] a_q,      a_d;      // operand A, shifted right each step
   logic [WIDTH-1:0] b_q,      b_d;      // operand B (inverted for subtract)
   logic [WIDTH-1:0] res_q,    res_d;    // sum bits enter at the MSB
   logic             carry_q,  carry_d;
   logic             c_msb_q,  c_msb_d;  // carry into the MSB step
   logic             sub_q,    sub_d;
   logic [CW-1:0]    cnt_q,    cnt_d;

   // ---------------------------------------------------------------------------
   // Single full-adder cell. It works on the current LSBs of the operand shift
   // registers.
   // ---------------------------------------------------------------------------
   logic fa_a;
   logic fa_b;
   logic fa_sum;
   logic fa_co;
   logic last_step;

   assign fa_a      = a_q[0];
   assign fa_b      = b_q[0];
   assign fa_sum    = fa_a ^ fa_b ^ carry_q;
   assign fa_co     = (fa_a & fa_b) | (carry_q & (fa_a ^ fa_b));
   assign last_step = (cnt_q == CW'(WIDTH - 1));

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default before the case statement. Any path
      // that leaves a signal unassigned would otherwise infer a latch.
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      carry_d = carry_q;
      c_msb_d = c_msb_q;
      sub_d   = sub_q;
      cnt_d   = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = sub ? ~b : b;
               carry_d = sub ? ~cin : cin;
               sub_d   = sub;
               cnt_d   = '0;
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            res_d   = {fa_sum, res_q[WIDTH-1:1]};
            carry_d = fa_co;
            cnt_d   = cnt_q + CW'(1);
            if (last_step) begin
               // The carry into the sign-bit step is needed for signed
               // overflow detection.
               c_msb_d = carry_q;
               state_d = ST_DONE;
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers. The datapath is only WIDTH bits wide and has a defined
   // reset value, so every register is reset.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         c_msb_q <= 1'b0;
         sub_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments. Every register samples the values
         // from before the edge, which keeps the shift chain intact.
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         c_msb_q <= c_msb_d;
         sub_q   <= sub_d;
         cnt_q   <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs. The handshake signals are decoded from state only.
   //
   // cout and ovf are decoded from the final carry. Nothing changes that carry
   // between DONE and the next accept, so both outputs stay stable until then.
   // For subtract, borrow is the inverse of the carry.
   // ---------------------------------------------------------------------------
   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign busy      = (state_q != ST_IDLE);
   assign result    = res_q;
   assign cout      = sub_q ^ carry_q;
   assign ovf       = c_msb_q ^ carry_q;

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
//
// Self-checking bench for serial_addsub (WIDTH = 4). The bench has three parts:
//   - a table of fixed vectors
//   - random operations checked against an arithmetic reference model
//   - hand-written sequences for backpressure, ignored in_valid and mid-op reset
// -----------------------------------------------------------------------------
module tb_serial_addsub;

   localparam int W   = 4;
   localparam int LAT = W + 1;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;
   logic         busy;

   int n_vec = 0;
   int n_err = 0;

   serial_addsub #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic         cin;
      logic [W-1:0] res;
      logic         cout;
      logic         ovf;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference model: plain integer arithmetic. Overflow means the exact signed
   // result falls outside the W-bit two's complement range.
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic ms, input logic mc,
                                 output logic [W-1:0] r, output logic co, output logic ov);
      int u;
      int sa;
      int sb;
      int sr;
      sa = (int'(ma) >= 2 ** (W - 1)) ? int'(ma) - 2 ** W : int'(ma);
      sb = (int'(mb) >= 2 ** (W - 1)) ? int'(mb) - 2 ** W : int'(mb);
      if (!ms) begin
         u  = int'(ma) + int'(mb) + int'(mc);
         co = (u >= 2 ** W);
         sr = sa + sb + int'(mc);
      end else begin
         u  = int'(ma) - int'(mb) - int'(mc);
         co = (int'(ma) < int'(mb) + int'(mc));
         sr = sa - sb - int'(mc);
      end
      r  = u[W-1:0];
      ov = (sr > 2 ** (W - 1) - 1) || (sr < -(2 ** (W - 1)));
   endfunction

   // Performs one operation: waits for in_ready, accepts the operands,
   // scrambles the inputs after the accept, then counts edges until out_valid.
   // The outputs are sampled 1 time unit after the edge.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic ts, input logic tc,
                         output logic [W-1:0] r, output logic co, output logic ov,
                         output int lat);
      int g;
      g = 0;
      while (!in_ready && g < 50) begin
         @(posedge clk);
         #1;
         g++;
      end
      a        = ta;
      b        = tb_;
      sub      = ts;
      cin      = tc;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = ~ta;
      b        = ~tb_;
      sub      = ~ts;
      cin      = ~tc;
      lat      = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      r  = result;
      co = cout;
      ov = ovf;
   endtask

   vec_t         tbl[6];
   logic [W-1:0] r;
   logic [W-1:0] er;
   logic [W-1:0] held;
   logic         co;
   logic         ov;
   logic         eco;
   logic         eov;
   int           lat;

   initial begin
      tbl[0] = '{4'b1001, 4'b0110, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b0};
      tbl[1] = '{4'b0111, 4'b0001, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1};
      tbl[2] = '{4'b1101, 4'b1010, 1'b0, 1'b1, 4'b1000, 1'b1, 1'b0};
      tbl[3] = '{4'b0010, 4'b1110, 1'b1, 1'b1, 4'b0011, 1'b1, 1'b0};
      tbl[4] = '{4'b0101, 4'b0011, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0};
      tbl[5] = '{4'b1000, 4'b0001, 1'b1, 1'b0, 4'b0111, 1'b0, 1'b1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      sub       = 1'b0;
      cin       = 1'b0;
      #12;
      check("rst_in_ready",  in_ready,  1);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy",      busy,      0);
      check("rst_result",    result,    0);
      check("rst_cout",      cout,      0);
      check("rst_ovf",       ovf,       0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fixed vectors. Each checks the result, latency and a one-cycle DONE.
      for (int i = 0; i < 6; i++) begin
         run_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, r, co, ov, lat);
         check($sformatf("tbl%0d_lat", i),  lat, LAT);
         check($sformatf("tbl%0d_res", i),  r,   tbl[i].res);
         check($sformatf("tbl%0d_cout", i), co,  tbl[i].cout);
         check($sformatf("tbl%0d_ovf", i),  ov,  tbl[i].ovf);
         check($sformatf("tbl%0d_busy", i), busy, 1);
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d_drop", i), out_valid, 0);
         check($sformatf("tbl%0d_idle", i), in_ready,  1);
         check($sformatf("tbl%0d_keep", i), result,    tbl[i].res);
      end

      // Random operations checked against the model.
      for (int i = 0; i < 40; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic         rs;
         logic         rc;
         ra = W'($urandom);
         rb = W'($urandom);
         rs = 1'($urandom);
         rc = 1'($urandom);
         model(ra, rb, rs, rc, er, eco, eov);
         run_op(ra, rb, rs, rc, r, co, ov, lat);
         check($sformatf("rnd%0d_lat", i),  lat, LAT);
         check($sformatf("rnd%0d_res", i),  r,   er);
         check($sformatf("rnd%0d_cout", i), co,  eco);
         check($sformatf("rnd%0d_ovf", i),  ov,  eov);
         @(posedge clk);
         #1;
         check($sformatf("rnd%0d_drop", i), out_valid, 0);
      end

      // Backpressure: hold DONE for 3 extra cycles.
      out_ready = 1'b0;
      run_op(4'b0111, 4'b0001, 1'b0, 1'b0, r, co, ov, lat);
      check("bp_lat", lat, LAT);
      check("bp_res", r, 4'b1000);
      held = r;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("bp%0d_valid", i), out_valid, 1);
         check($sformatf("bp%0d_res", i),   result,    held);
         check($sformatf("bp%0d_ovf", i),   ovf,       1);
         check($sformatf("bp%0d_ready", i), in_ready,  0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_exit_valid", out_valid, 0);
      check("bp_exit_ready", in_ready,  1);

      // in_valid pulsed with other operands while shifting must be ignored.
      a        = 4'b1001;
      b        = 4'b0110;
      sub      = 1'b0;
      cin      = 1'b0;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      lat = 1;
      while (!out_valid && lat < 20) begin
         a        = 4'b0011;
         b        = 4'b0101;
         sub      = 1'b1;
         cin      = 1'b1;
         in_valid = 1'b1;
         check($sformatf("iv%0d_ready", lat), in_ready, 0);
         @(posedge clk);
         #1;
         lat++;
      end
      in_valid = 1'b0;
      check("iv_lat",  lat,    LAT);
      check("iv_res",  result, 4'b1111);
      check("iv_cout", cout,   0);
      @(posedge clk);
      #1;
      check("iv_drop", out_valid, 0);

      // Leave a nonzero cout/ovf behind, then reset after 2 SHIFT steps.
      run_op(4'b1101, 4'b1010, 1'b0, 1'b1, r, co, ov, lat);
      check("pre_rst_cout", co, 1);
      @(posedge clk);
      #1;
      a        = 4'b0111;
      b        = 4'b0111;
      sub      = 1'b0;
      cin      = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("arst_in_ready",  in_ready,  1);
      check("arst_out_valid", out_valid, 0);
      check("arst_busy",      busy,      0);
      check("arst_result",    result,    0);
      check("arst_cout",      cout,      0);
      check("arst_ovf",       ovf,       0);
      @(posedge clk);
      #1;
      check("arst_hold_valid", out_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(4'b1001, 4'b0110, 1'b0, 1'b0, r, co, ov, lat);
      check("post_rst_lat",  lat, LAT);
      check("post_rst_res",  r,   4'b1111);
      check("post_rst_cout", co,  0);
      check("post_rst_ovf",  ov,  0);
      @(posedge clk);
      #1;
      check("post_rst_drop", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
